// File: rtl/ones_counter_seq_if.sv
// Handshake bundle for ones_counter_seq: a word input channel and a
// population-count result channel, both valid/ready.
interface ones_counter_seq_if #(
  parameter int WIDTH = 127,
  parameter int ACCW  = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [ACCW-1:0]  out_count;
  logic             out_ovf;

  // Word source / result consumer side
  modport master (
    output in_valid, in_data, in_last, in_mode, out_ready,
    input  in_ready, out_valid, out_count, out_ovf
  );

  // Counter side
  modport slave (
    input  in_valid, in_data, in_last, in_mode, out_ready,
    output in_ready, out_valid, out_count, out_ovf
  );
endinterface

// File: rtl/ones_counter_seq.sv
// Sequential ones counter. A word is loaded into a shift register and its
// set bits are counted CHUNK at a time into a saturating accumulator, either
// per word or summed over a frame of words terminated by in_last.
module ones_counter_seq #(
  parameter int WIDTH = 127,
  parameter int CHUNK = 16,
  parameter int ACCW  = 16
) (
  input logic                clk,
  input logic                rst_n,
  ones_counter_seq_if.slave  bus
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int SHW    = NCHUNK * CHUNK;
  localparam int CNTW   = $clog2(NCHUNK + 1);
  localparam int POPW   = $clog2(CHUNK + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [SHW-1:0]  shreg;
  logic [CNTW-1:0] chunk_cnt;
  logic [ACCW-1:0] acc;
  logic            ovf;
  logic            mode_q;
  logic            last_q;
  logic            mid_frame;
  logic [POPW-1:0] chunk_pop;
  logic [ACCW:0]   sum;
  logic            chunks_done;
  logic            accept;
  logic            consume;

  // The cycle after the last chunk only steers to DONE or back to IDLE
  assign chunks_done = (chunk_cnt == CNTW'(NCHUNK));
  assign accept      = bus.in_valid  && (state == IDLE);
  assign consume     = bus.out_ready && (state == DONE);

  assign bus.out_count = acc;
  assign bus.out_ovf   = ovf;

  // Popcount of the low chunk and the widened sum used for saturation
  always_comb begin
    chunk_pop = '0;
    for (int i = 0; i < CHUNK; i++) begin
      chunk_pop = chunk_pop + POPW'(shreg[i]);
    end
    sum = {1'b0, acc} + (ACCW + 1)'(chunk_pop);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = COUNT;
      end
      COUNT: begin
        if (chunks_done) state_nxt = (!mode_q || last_q) ? DONE : IDLE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load, chunked accumulate with saturation, result clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg     <= '0;
      chunk_cnt <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      mode_q    <= 1'b0;
      last_q    <= 1'b0;
      mid_frame <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg     <= SHW'(bus.in_data);
            last_q    <= bus.in_last;
            chunk_cnt <= '0;
            if (!mid_frame) mode_q <= bus.in_mode;
          end
        end
        COUNT: begin
          if (!chunks_done) begin
            if (sum > {1'b0, {ACCW{1'b1}}}) begin
              acc <= {ACCW{1'b1}};
              ovf <= 1'b1;
            end else begin
              acc <= sum[ACCW-1:0];
            end
            shreg     <= shreg >> CHUNK;
            chunk_cnt <= chunk_cnt + CNTW'(1);
          end else begin
            mid_frame <= mode_q && !last_q;
          end
        end
        DONE: begin
          if (consume) begin
            acc <= '0;
            ovf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ones_counter_seq.sv
// Directed bench for ones_counter_seq: a 16-bit accumulator instance for
// the main scenarios and an 8-bit accumulator instance for saturation.
module tb_ones_counter_seq;

  logic clk;
  logic rst_n;
  int   num_checks;
  int   num_fails;

  ones_counter_seq_if #(.WIDTH(127), .ACCW(16)) a ();
  ones_counter_seq_if #(.WIDTH(127), .ACCW(8))  b ();

  ones_counter_seq #(.WIDTH(127), .CHUNK(16), .ACCW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a)
  );

  ones_counter_seq #(.WIDTH(127), .CHUNK(16), .ACCW(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    assert (observed === expected)
    else begin
      num_fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit sel, input logic [126:0] data,
                               input logic last, input logic mode);
    if (!sel) begin
      checkOutput("a_ready_at_accept", 32'(a.in_ready), 32'd1);
      a.in_valid = 1'b1; a.in_data = data; a.in_last = last; a.in_mode = mode;
    end else begin
      checkOutput("b_ready_at_accept", 32'(b.in_ready), 32'd1);
      b.in_valid = 1'b1; b.in_data = data; b.in_last = last; b.in_mode = mode;
    end
    @(posedge clk); #1;
    a.in_valid = 1'b0; a.in_data = 'x; a.in_last = 1'b0; a.in_mode = 1'b0;
    b.in_valid = 1'b0; b.in_data = 'x; b.in_last = 1'b0; b.in_mode = 1'b0;
  endtask

  task automatic waitResult(input bit sel, output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if ((!sel && a.out_valid) || (sel && b.out_valid)) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic takeResult(input bit sel);
    if (!sel) a.out_ready = 1'b1; else b.out_ready = 1'b1;
    @(posedge clk); #1;
    a.out_ready = 1'b0;
    b.out_ready = 1'b0;
  endtask

  // Nine edges of a non-final accumulate word: no result may appear
  task automatic idleWord(input bit sel, input string tag);
    logic seen;
    seen = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
      seen = seen | (sel ? b.out_valid : a.out_valid);
    end
    checkOutput(tag, 32'(seen), 32'd0);
    checkOutput("ready_after_word", 32'(sel ? b.in_ready : a.in_ready), 32'd1);
  endtask

  // Directed scenario sequence
  initial begin
    logic [126:0] ones;
    logic [126:0] alt;
    logic         stable;
    int           n;

    num_checks = 0;
    num_fails  = 0;
    ones = '1;
    for (int i = 0; i < 127; i++) alt[i] = i[0];

    a.in_valid = 1'b0; a.in_data = '0; a.in_last = 1'b0; a.in_mode = 1'b0; a.out_ready = 1'b0;
    b.in_valid = 1'b0; b.in_data = '0; b.in_last = 1'b0; b.in_mode = 1'b0; b.out_ready = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(a.in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(a.out_valid), 32'd0);
    checkOutput("rst_out_count", 32'(a.out_count), 32'd0);
    checkOutput("rst_out_ovf", 32'(a.out_ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] all-ones word, per-word mode");
    applyStimulus(1'b0, ones, 1'b0, 1'b0);
    waitResult(1'b0, n);
    checkOutput("t1_latency", 32'(n), 32'd9);
    checkOutput("t1_count", 32'(a.out_count), 32'd127);
    checkOutput("t1_ovf", 32'(a.out_ovf), 32'd0);
    checkOutput("t1_ready_in_done", 32'(a.in_ready), 32'd0);
    takeResult(1'b0);
    checkOutput("t1_ready_after", 32'(a.in_ready), 32'd1);
    checkOutput("t1_valid_after", 32'(a.out_valid), 32'd0);

    $display("[TB] alternating word then zero word");
    applyStimulus(1'b0, alt, 1'b1, 1'b0);
    checkOutput("t2_ready_in_count", 32'(a.in_ready), 32'd0);
    waitResult(1'b0, n);
    checkOutput("t2_latency_a", 32'(n), 32'd9);
    checkOutput("t2_count_a", 32'(a.out_count), 32'd63);
    takeResult(1'b0);
    applyStimulus(1'b0, 127'd0, 1'b0, 1'b0);
    waitResult(1'b0, n);
    checkOutput("t2_latency_b", 32'(n), 32'd9);
    checkOutput("t2_count_b", 32'(a.out_count), 32'd0);
    takeResult(1'b0);

    $display("[TB] three-word accumulate frame with backpressure");
    applyStimulus(1'b0, ones, 1'b0, 1'b1);
    idleWord(1'b0, "t3_no_valid_w1");
    applyStimulus(1'b0, ones, 1'b0, 1'b0);
    idleWord(1'b0, "t3_no_valid_w2");
    applyStimulus(1'b0, ones, 1'b1, 1'b0);
    waitResult(1'b0, n);
    checkOutput("t3_latency", 32'(n), 32'd9);
    checkOutput("t3_count", 32'(a.out_count), 32'd381);
    checkOutput("t3_ovf", 32'(a.out_ovf), 32'd0);
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (a.out_valid !== 1'b1 || a.out_count !== 16'd381 ||
          a.out_ovf !== 1'b0 || a.in_ready !== 1'b0) stable = 1'b0;
    end
    checkOutput("t4_hold_stable", 32'(stable), 32'd1);
    takeResult(1'b0);
    checkOutput("t4_ready_after", 32'(a.in_ready), 32'd1);
    checkOutput("t4_valid_after", 32'(a.out_valid), 32'd0);
    checkOutput("t4_count_cleared", 32'(a.out_count), 32'd0);

    $display("[TB] 8-bit accumulator saturation");
    applyStimulus(1'b1, ones, 1'b0, 1'b1);
    idleWord(1'b1, "t5_no_valid_w1");
    applyStimulus(1'b1, ones, 1'b0, 1'b1);
    idleWord(1'b1, "t5_no_valid_w2");
    applyStimulus(1'b1, ones, 1'b1, 1'b1);
    waitResult(1'b1, n);
    checkOutput("t5_latency", 32'(n), 32'd9);
    checkOutput("t5_count_sat", 32'(b.out_count), 32'd255);
    checkOutput("t5_ovf_sat", 32'(b.out_ovf), 32'd1);
    takeResult(1'b1);
    applyStimulus(1'b1, 127'h7, 1'b1, 1'b1);
    waitResult(1'b1, n);
    checkOutput("t5_count_next", 32'(b.out_count), 32'd3);
    checkOutput("t5_ovf_next", 32'(b.out_ovf), 32'd0);
    takeResult(1'b1);

    $display("[TB] reset during COUNT");
    applyStimulus(1'b0, ones, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("t6_ready", 32'(a.in_ready), 32'd1);
    checkOutput("t6_valid", 32'(a.out_valid), 32'd0);
    checkOutput("t6_count", 32'(a.out_count), 32'd0);
    stable = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      stable = stable | a.out_valid;
    end
    checkOutput("t6_nothing_emitted", 32'(stable), 32'd0);
    applyStimulus(1'b0, 127'h1F, 1'b0, 1'b0);
    waitResult(1'b0, n);
    checkOutput("t6_latency", 32'(n), 32'd9);
    checkOutput("t6_count_new", 32'(a.out_count), 32'd5);
    takeResult(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
